vn_output_collector: RTL and testbench

Sink-side collector for the virtual-neuron (VN) output bus of an edge adder switch. It accepts up to two VN results per cycle from the switch's registered `o_vn`/`o_vn_valid` outputs and buffers them, in order, in a dual-write / single-read FIFO. Each result is tagged with a running output index and drained one per cycle to writeback through a valid/ready handshake. The switch has no backpressure input, so the collector raises an early stall to the controller and records any loss in a sticky overflow flag.

---
 rtl/funnel_pkg.sv | 10 +
 rtl/vn_output_collector_if.sv | 28 ++
 rtl/vn_fifo_2w1r.sv | 48 ++++
 rtl/vn_output_collector.sv | 77 +++++++
 tb/tb_vn_output_collector.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/funnel_pkg.sv
// Constants shared by the VN output funnel blocks.
package funnel_pkg;
    localparam int VN_LANE_LO        = 0;
    localparam int VN_LANE_HI        = 1;
    localparam int VN_STALL_HEADROOM = 4;

    function automatic logic [1:0] popcnt2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction
endpackage

// File: rtl/vn_output_collector_if.sv
// VN result bus from the switch plus the writeback drain handshake.
interface vn_output_collector_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int IDX_W      = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [2*DATA_WIDTH-1:0] i_vn;
    logic [1:0]              i_vn_valid;
    logic                    i_clear;
    logic [DATA_WIDTH-1:0]   o_data;
    logic [IDX_W-1:0]        o_idx;
    logic                    o_valid;
    logic                    i_ready;
    logic                    o_stall;
    logic                    o_overflow;
    logic [CNT_W-1:0]        o_count;

    modport master (
        input  i_vn, i_vn_valid, i_clear, i_ready,
        output o_data, o_idx, o_valid, o_stall, o_overflow, o_count
    );
    modport slave (
        output i_vn, i_vn_valid, i_clear, i_ready,
        input  o_data, o_idx, o_valid, o_stall, o_overflow, o_count
    );
endinterface

// File: rtl/vn_fifo_2w1r.sv
// Two-write / one-read circular FIFO. Port 1 lands in the slot after port 0.
module vn_fifo_2w1r #(
    parameter int W     = 48,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [1:0]          wr_en,
    input  logic [1:0][W-1:0]   wr_data,
    input  logic                rd_en,
    output logic [W-1:0]        rd_data,
    output logic [CNT_W-1:0]    count,
    output logic [CNT_W-1:0]    full_space
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [1:0]       n_wr;

    assign n_wr = {1'b0, wr_en[0]} + {1'b0, wr_en[1]};

    // Storage is not reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (wr_en[0]) mem[wptr]                 <= wr_data[0];
        if (wr_en[1]) mem[wptr + PTR_W'(1)]     <= wr_data[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PTR_W'(n_wr);
            rptr  <= rptr + PTR_W'(rd_en);
            count <= count + CNT_W'(n_wr) - CNT_W'(rd_en);
        end
    end

    assign rd_data    = mem[rptr];
    assign full_space = CNT_W'(DEPTH) - count;
endmodule

// File: rtl/vn_output_collector.sv
// Collects up to two VN results per cycle, tags them with a running index and
// drains them one per cycle; raises stall early and flags any dropped result.
module vn_output_collector
    import funnel_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int IDX_W      = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    vn_output_collector_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int W     = DATA_WIDTH + IDX_W;

    logic [1:0]              vld;
    logic [DATA_WIDTH-1:0]   lane_lo, lane_hi;
    logic [1:0]              n_push;
    logic                    clr, pop, drop;
    logic [CNT_W-1:0]        count, full_space, free;
    logic [1:0]              wr_en;
    logic [1:0][W-1:0]       wr_data;
    logic [W-1:0]            rd_data;
    logic [IDX_W-1:0]        idx_cnt;
    logic                    ovf;

    assign clr     = bus.i_clear;
    assign vld     = bus.i_vn_valid;
    assign lane_lo = bus.i_vn[VN_LANE_LO*DATA_WIDTH +: DATA_WIDTH];
    assign lane_hi = bus.i_vn[VN_LANE_HI*DATA_WIDTH +: DATA_WIDTH];
    assign n_push  = popcnt2(vld);

    assign pop  = bus.o_valid & bus.i_ready & ~clr;
    // A pop this cycle frees its slot for this cycle's pushes.
    assign free = full_space + CNT_W'(pop);

    assign wr_en[0] = !clr && (n_push != 2'd0) && (free >= CNT_W'(1));
    assign wr_en[1] = !clr && (n_push == 2'd2) && (free >= CNT_W'(2));
    assign drop     = !clr && (CNT_W'(n_push) > free);

    // Compaction: a lone lane 1 result goes through port 0.
    assign wr_data[0] = {idx_cnt, vld[VN_LANE_LO] ? lane_lo : lane_hi};
    assign wr_data[1] = {idx_cnt + IDX_W'(1), lane_hi};

    vn_fifo_2w1r #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (pop),
        .rd_data    (rd_data),
        .count      (count),
        .full_space (full_space)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_cnt <= '0;
            ovf     <= 1'b0;
        end else if (clr) begin
            idx_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            idx_cnt <= idx_cnt + IDX_W'(wr_en[0]) + IDX_W'(wr_en[1]);
            ovf     <= ovf | drop;
        end
    end

    assign bus.o_valid    = (count != '0);
    assign bus.o_data     = bus.o_valid ? rd_data[DATA_WIDTH-1:0] : '0;
    assign bus.o_idx      = bus.o_valid ? rd_data[W-1:DATA_WIDTH] : '0;
    assign bus.o_count    = count;
    assign bus.o_stall    = full_space < CNT_W'(VN_STALL_HEADROOM);
    assign bus.o_overflow = ovf;
endmodule

// File: tb/tb_vn_output_collector.sv
// Directed vector bench for vn_output_collector (DEPTH=8, 32-bit data, 16-bit idx).
module tb_vn_output_collector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vn_output_collector_if #(.DATA_WIDTH(32), .DEPTH(8), .IDX_W(16)) bus ();

    vn_output_collector #(.DATA_WIDTH(32), .DEPTH(8), .IDX_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [1:0]  vv;
        logic [31:0] l0;
        logic [31:0] l1;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic [15:0] ei;
        logic [3:0]  ec;
        logic        es;
        logic        eo;
    } vec_t;

    vec_t vecs[$];
    int   n_applied = 0;
    int   miscompares = 0;

    function automatic void add(input logic clr, input logic [1:0] vv,
                                input logic [31:0] l0, input logic [31:0] l1,
                                input logic rdy, input logic ev,
                                input logic [31:0] ed, input logic [15:0] ei,
                                input logic [3:0] ec, input logic es,
                                input logic eo);
        vec_t v;
        v.clr = clr; v.vv = vv; v.l0 = l0; v.l1 = l1; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.ei = ei; v.ec = ec; v.es = es; v.eo = eo;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int k,
                       input logic [63:0] got, input logic [63:0] exp);
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s (vec %0d): got %0h, expected %0h", nm, k, got, exp);
        end
    endtask

    task automatic chk_all(input int k, input logic ev, input logic [31:0] ed,
                           input logic [15:0] ei, input logic [3:0] ec,
                           input logic es, input logic eo);
        n_applied++;
        chk("o_valid",    k, 64'(bus.o_valid),    64'(ev));
        chk("o_data",     k, 64'(bus.o_data),     64'(ed));
        chk("o_idx",      k, 64'(bus.o_idx),      64'(ei));
        chk("o_count",    k, 64'(bus.o_count),    64'(ec));
        chk("o_stall",    k, 64'(bus.o_stall),    64'(es));
        chk("o_overflow", k, 64'(bus.o_overflow), 64'(eo));
    endtask

    task automatic drive(input logic clr, input logic [1:0] vv,
                         input logic [31:0] l0, input logic [31:0] l1,
                         input logic rdy);
        bus.i_clear    = clr;
        bus.i_vn_valid = vv;
        bus.i_vn       = {l1, l0};
        bus.i_ready    = rdy;
    endtask

    initial begin
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);

        // pair push then drain
        add(0, 2'b11, 32'h3F800000, 32'h40000000, 1, 1, 32'h3F800000, 16'd0, 4'd2, 0, 0);
        add(0, 2'b00, 32'h0,        32'h0,        1, 1, 32'h40000000, 16'd1, 4'd1, 0, 0);
        add(0, 2'b00, 32'h0,        32'h0,        1, 0, 32'h0,        16'd0, 4'd0, 0, 0);
        // clear, then lane-1-only push is compacted
        add(1, 2'b00, 32'h0,        32'h0,        0, 0, 32'h0,        16'd0, 4'd0, 0, 0);
        add(0, 2'b10, 32'hDEAD0000, 32'h40400000, 0, 1, 32'h40400000, 16'd0, 4'd1, 0, 0);
        // fill with no pops
        add(0, 2'b11, 32'h10, 32'h11, 0, 1, 32'h40400000, 16'd0, 4'd3, 0, 0);
        add(0, 2'b01, 32'h12, 32'h0,  0, 1, 32'h40400000, 16'd0, 4'd4, 0, 0);
        add(0, 2'b01, 32'h13, 32'h0,  0, 1, 32'h40400000, 16'd0, 4'd5, 1, 0);
        add(0, 2'b11, 32'h14, 32'h15, 0, 1, 32'h40400000, 16'd0, 4'd7, 1, 0);
        // one free slot: lane 0 kept (idx 7), lane 1 dropped
        add(0, 2'b11, 32'h16, 32'hBAD1, 0, 1, 32'h40400000, 16'd0, 4'd8, 1, 1);
        // full: both dropped, index counter must not move
        add(0, 2'b11, 32'hBAD2, 32'hBAD3, 0, 1, 32'h40400000, 16'd0, 4'd8, 1, 1);
        // full with pop: push accepted in freed slot
        add(0, 2'b01, 32'h18, 32'h0,  1, 1, 32'h10, 16'd1, 4'd8, 1, 1);
        // drain, checking order and idx continuity
        add(0, 2'b00, 32'h0, 32'h0, 1, 1, 32'h11, 16'd2, 4'd7, 1, 1);
        add(0, 2'b00, 32'h0, 32'h0, 1, 1, 32'h12, 16'd3, 4'd6, 1, 1);
        add(0, 2'b00, 32'h0, 32'h0, 1, 1, 32'h13, 16'd4, 4'd5, 1, 1);
        add(0, 2'b00, 32'h0, 32'h0, 1, 1, 32'h14, 16'd5, 4'd4, 0, 1);
        add(0, 2'b00, 32'h0, 32'h0, 1, 1, 32'h15, 16'd6, 4'd3, 0, 1);
        add(0, 2'b00, 32'h0, 32'h0, 1, 1, 32'h16, 16'd7, 4'd2, 0, 1);
        add(0, 2'b00, 32'h0, 32'h0, 1, 1, 32'h18, 16'd8, 4'd1, 0, 1);
        add(0, 2'b00, 32'h0, 32'h0, 1, 0, 32'h0,  16'd0, 4'd0, 0, 1);
        // refill a little, then clear together with a push
        add(0, 2'b11, 32'h30, 32'h31, 0, 1, 32'h30, 16'd9, 4'd2, 0, 1);
        add(1, 2'b11, 32'hBAD4, 32'hBAD5, 1, 0, 32'h0, 16'd0, 4'd0, 0, 0);
        add(0, 2'b01, 32'h20, 32'h0,  0, 1, 32'h20, 16'd0, 4'd1, 0, 0);
        add(0, 2'b11, 32'h21, 32'h22, 0, 1, 32'h20, 16'd0, 4'd3, 0, 0);
        add(0, 2'b00, 32'h0, 32'h0,   1, 1, 32'h21, 16'd1, 4'd2, 0, 0);

        // reset state
        #1;
        chk_all(-1, 0, 32'h0, 16'h0, 4'd0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].clr, vecs[k].vv, vecs[k].l0, vecs[k].l1, vecs[k].rdy);
            @(posedge clk);
            #1;
            chk_all(k, vecs[k].ev, vecs[k].ed, vecs[k].ei, vecs[k].ec,
                    vecs[k].es, vecs[k].eo);
        end

        // async reset mid-drain: outputs clear without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk_all(100, 0, 32'h0, 16'h0, 4'd0, 0, 0);
        @(negedge clk);
        drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b0, 2'b01, 32'h55, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        chk_all(101, 1, 32'h55, 16'd0, 4'd1, 0, 0);
        @(negedge clk);
        drive(1'b0, 2'b10, 32'h0, 32'h56, 1'b1);
        @(posedge clk);
        #1;
        chk_all(102, 1, 32'h56, 16'd1, 4'd1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, miscompares);
        $finish;
    end
endmodule
